// File: rtl/window_conv3x3.sv
`default_nettype none
// ============================================================================
//  Module      : window_conv3x3
//  Description : Consumer end of the 3-row line-buffer column stream. Accepts
//                one vertical 3-pixel column per cycle, builds a sliding 3x3
//                window and emits a Gaussian-blurred pixel
//                (kernel [1 2 1; 2 4 2; 1 2 1] / 16) for every interior column.
//                Drives the idle/done handshake back to the line buffer.
//
//  Parameters  : WIDTH   pixels per image row, 3..255
//                HEIGHT  image rows, 3..255 (HEIGHT-2 window rows per frame)
//
//  Ports       : clk            rising-edge clock
//                rst_n          asynchronous active-low reset
//                ready_i        line buffer presents a valid column
//                fifo1_data_i   column pixel, top row
//                fifo2_data_i   column pixel, middle row
//                fifo3_data_i   column pixel, bottom row
//                idle_o         1 = block accepts columns
//                done_o         1-cycle pulse, row consumed
//                pix_o          filtered pixel
//                pix_valid_o    pix_o valid this cycle
//                pix_x_o        output column index 0..WIDTH-3
//                frame_done_o   sticky, all HEIGHT-2 rows consumed
//
//  Configuration macro:
//                ROUND_NEAREST_EN  defined   -> pix_o = (acc + 8) >> 4
//                                  undefined -> pix_o = acc >> 4 (truncate)
//
//  Revision    : 1.0  initial release
// ============================================================================
module window_conv3x3 #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ready_i,
    input  logic [7:0] fifo1_data_i,
    input  logic [7:0] fifo2_data_i,
    input  logic [7:0] fifo3_data_i,
    output logic       idle_o,
    output logic       done_o,
    output logic [7:0] pix_o,
    output logic       pix_valid_o,
    output logic [7:0] pix_x_o,
    output logic       frame_done_o
);

    // ------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    localparam logic [7:0] c_LAST_COL = 8'(WIDTH - 1);
    localparam logic [7:0] c_LAST_ROW = 8'(HEIGHT - 2);

`ifdef ROUND_NEAREST_EN
    localparam logic [11:0] c_RND_BIAS = 12'd8;
`else
    localparam logic [11:0] c_RND_BIAS = 12'd0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_col_cnt;
    logic [7:0]  r_row_cnt;
    logic [7:0]  w_row_inc;
    logic        w_capture;

    // Column sums of the three most recent columns, c2 newest.
    logic [9:0]  r_c0;
    logic [9:0]  r_c1;
    logic [9:0]  r_c2;
    logic [9:0]  w_colsum;
    logic [11:0] w_acc;
    logic [11:0] w_acc_rnd;
    logic [7:0]  w_pix;

    logic [7:0]  r_pix;
    logic        r_pix_valid;
    logic [7:0]  r_pix_x;
    logic        r_frame_done;

    // A column is taken only while waiting for or receiving a row; S_DONE
    // ignores ready_i because the line buffer still holds stale data there.
    assign w_capture = ready_i && ((r_state == S_WAIT) || (r_state == S_RECV));
    assign w_row_inc = r_row_cnt + 8'd1;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    assign w_colsum = {2'b00, fifo1_data_i}
                    + {1'b0, fifo2_data_i, 1'b0}
                    + {2'b00, fifo3_data_i};

    // Horizontal weighting over the window as it looks after this capture:
    // oldest column is the current c1, centre is c2, newest is w_colsum.
    assign w_acc = {2'b00, r_c1}
                 + {1'b0, r_c2, 1'b0}
                 + {2'b00, w_colsum};

    // Max 4080 + 8 = 4088 fits 12 bits, and 4088 >> 4 = 255: no saturation.
    assign w_acc_rnd = w_acc + c_RND_BIAS;
    assign w_pix     = 8'(w_acc_rnd >> 4);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (ready_i) begin
                    w_state_next = S_RECV;
                end
            end
            S_RECV: begin
                if (ready_i && (r_col_cnt == c_LAST_COL)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_row_inc == c_LAST_ROW) begin
                    w_state_next = S_END;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_END: begin
                w_state_next = S_END;
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        idle_o = 1'b1;
        done_o = 1'b0;
        case (r_state)
            S_DONE: begin
                done_o = 1'b1;
            end
            S_END: begin
                idle_o = 1'b0;
            end
            default: begin
                idle_o = 1'b1;
                done_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Column / row counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= 8'd0;
            r_row_cnt <= 8'd0;
        end else if (w_capture) begin
            r_col_cnt <= r_col_cnt + 8'd1;
        end else if (r_state == S_DONE) begin
            r_col_cnt <= 8'd0;
            r_row_cnt <= w_row_inc;
        end
    end

    // ------------------------------------------------------------------
    // Column-sum shift register; cleared between rows so a window never
    // mixes columns from two different rows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c0 <= 10'd0;
            r_c1 <= 10'd0;
            r_c2 <= 10'd0;
        end else if (w_capture) begin
            r_c0 <= r_c1;
            r_c1 <= r_c2;
            r_c2 <= w_colsum;
        end else if (r_state == S_DONE) begin
            r_c0 <= 10'd0;
            r_c1 <= 10'd0;
            r_c2 <= 10'd0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel output register: the third and later columns of a row each
    // complete a window. pix_o / pix_x_o hold between valid pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix       <= 8'd0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 8'd0;
        end else begin
            r_pix_valid <= 1'b0;
            if (w_capture && (r_col_cnt >= 8'd2)) begin
                r_pix       <= w_pix;
                r_pix_valid <= 1'b1;
                r_pix_x     <= r_col_cnt - 8'd2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky frame-complete flag, rises together with entry to S_END.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else if ((r_state == S_DONE) && (w_row_inc == c_LAST_ROW)) begin
            r_frame_done <= 1'b1;
        end
    end

    assign pix_o        = r_pix;
    assign pix_valid_o  = r_pix_valid;
    assign pix_x_o      = r_pix_x;
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_window_conv3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_conv3x3
//  Description : Directed self-checking bench for window_conv3x3 with
//                WIDTH=5, HEIGHT=5 (3 output pixels per row, 3 rows/frame).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_window_conv3x3;

    logic       clk;
    logic       rst_n;
    logic       ready_i;
    logic [7:0] fifo1_data_i;
    logic [7:0] fifo2_data_i;
    logic [7:0] fifo3_data_i;
    logic       idle_o;
    logic       done_o;
    logic [7:0] pix_o;
    logic       pix_valid_o;
    logic [7:0] pix_x_o;
    logic       frame_done_o;

    int errors = 0;
    int checks = 0;

    // Observed output stream, collected on the falling edge.
    logic [7:0] q_pix[$];
    logic [7:0] q_x[$];
    int         done_cnt = 0;

    window_conv3x3 #(.WIDTH(5), .HEIGHT(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready_i      (ready_i),
        .fifo1_data_i (fifo1_data_i),
        .fifo2_data_i (fifo2_data_i),
        .fifo3_data_i (fifo3_data_i),
        .idle_o       (idle_o),
        .done_o       (done_o),
        .pix_o        (pix_o),
        .pix_valid_o  (pix_valid_o),
        .pix_x_o      (pix_x_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid_o) begin
            q_pix.push_back(pix_o);
            q_x.push_back(pix_x_o);
        end
        if (done_o) begin
            done_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus primitives (drive only, no checking)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n        = 1'b0;
        ready_i      = 1'b0;
        fifo1_data_i = 8'd0;
        fifo2_data_i = 8'd0;
        fifo3_data_i = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_pix.delete();
        q_x.delete();
        done_cnt = 0;
    endtask

    task automatic send_col(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        ready_i      = 1'b1;
        fifo1_data_i = t;
        fifo2_data_i = m;
        fifo3_data_i = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        ready_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full row of a constant pixel value, then the S_DONE cycle with ready low.
    task automatic send_row_const(input logic [7:0] v);
        for (int i = 0; i < 5; i++) send_col(v, v, v);
        idle_cycles(1);
    endtask

    // Column k carries pixel 16*k on all three rows -> outputs 16, 32, 48.
    task automatic send_row_ramp();
        for (int i = 0; i < 5; i++) send_col(8'(16 * i), 8'(16 * i), 8'(16 * i));
        idle_cycles(1);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({idle_o, done_o, pix_o, pix_valid_o, pix_x_o, frame_done_o} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: idle=%0b done=%0b pix=%0d valid=%0b x=%0d fd=%0b, required 1 0 0 0 0 0",
                     idle_o, done_o, pix_o, pix_valid_o, pix_x_o, frame_done_o);
        end
    endtask

    task automatic test_uniform();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            send_row_const(8'd100);
            checks++;
            if (done_cnt !== r + 1) begin
                errors++;
                $display("FAIL uniform_done_cnt row %0d: got %0d, required %0d", r, done_cnt, r + 1);
            end
            checks++;
            if (frame_done_o !== (r == 2)) begin
                errors++;
                $display("FAIL uniform_frame_done row %0d: got %0b, required %0b", r, frame_done_o, (r == 2));
            end
        end
        checks++;
        if (q_pix.size() !== 9) begin
            errors++;
            $display("FAIL uniform_count: got %0d pixels, required 9", q_pix.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (q_pix[i] !== 8'd100 || q_x[i] !== 8'(i % 3)) begin
                    errors++;
                    $display("FAIL uniform_pix %0d: got pix=%0d x=%0d, required pix=100 x=%0d", i, q_pix[i], q_x[i], i % 3);
                end
            end
        end
        checks++;
        if (idle_o !== 1'b0) begin
            errors++;
            $display("FAIL uniform_end_idle: got %0b, required 0", idle_o);
        end
        // Inputs are ignored once the frame is complete.
        send_row_const(8'd50);
        checks++;
        if (q_pix.size() !== 9 || done_cnt !== 3 || frame_done_o !== 1'b1) begin
            errors++;
            $display("FAIL end_ignores_input: got pixels=%0d done=%0d fd=%0b, required 9 3 1", q_pix.size(), done_cnt, frame_done_o);
        end
    endtask

    task automatic test_impulse();
        logic [7:0] exp_pix [3];
`ifdef ROUND_NEAREST_EN
        exp_pix = '{8'd2, 8'd1, 8'd0};
`else
        exp_pix = '{8'd1, 8'd0, 8'd0};
`endif
        do_reset();
        send_col(8'd0, 8'd0, 8'd0);
        send_col(8'd0, 8'd6, 8'd0);
        send_col(8'd0, 8'd0, 8'd0);
        send_col(8'd0, 8'd0, 8'd0);
        send_col(8'd0, 8'd0, 8'd0);
        idle_cycles(1);
        checks++;
        if (q_pix.size() !== 3) begin
            errors++;
            $display("FAIL impulse_count: got %0d pixels, required 3", q_pix.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pix[i] !== exp_pix[i]) begin
                    errors++;
                    $display("FAIL impulse_pix x=%0d: got %0d, required %0d", i, q_pix[i], exp_pix[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        send_row_const(8'd255);
        checks++;
        if (q_pix.size() !== 3) begin
            errors++;
            $display("FAIL max_count: got %0d pixels, required 3", q_pix.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pix[i] !== 8'd255) begin
                    errors++;
                    $display("FAIL max_pix x=%0d: got %0d, required 255", i, q_pix[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_pix [3];
        exp_pix = '{8'd16, 8'd32, 8'd48};
        do_reset();
        send_col(8'd0, 8'd0, 8'd0);
        send_col(8'd16, 8'd16, 8'd16);
        send_col(8'd32, 8'd32, 8'd32);
        // First stall cycle carries the pixel of column 2; the next two must be quiet.
        idle_cycles(1);
        for (int i = 0; i < 2; i++) begin
            idle_cycles(1);
            checks++;
            if (pix_valid_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_quiet cycle %0d: got valid=%0b done=%0b, required 0 0", i + 1, pix_valid_o, done_o);
            end
        end
        send_col(8'd48, 8'd48, 8'd48);
        checks++;
        if (done_cnt !== 0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_early_done: got done_cnt=%0d done=%0b after 4 captures, required 0 0", done_cnt, done_o);
        end
        send_col(8'd64, 8'd64, 8'd64);
        idle_cycles(1);
        checks++;
        if (done_cnt !== 1 || q_pix.size() !== 3) begin
            errors++;
            $display("FAIL stall_row: got done_cnt=%0d pixels=%0d, required 1 3", done_cnt, q_pix.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pix[i] !== exp_pix[i] || q_x[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL stall_pix %0d: got pix=%0d x=%0d, required pix=%0d x=%0d", i, q_pix[i], q_x[i], exp_pix[i], i);
                end
            end
        end
    endtask

    task automatic test_done_ready_held();
        logic [7:0] exp_pix [3];
        exp_pix = '{8'd16, 8'd32, 8'd48};
        do_reset();
        for (int i = 0; i < 5; i++) send_col(8'(16 * i), 8'(16 * i), 8'(16 * i));
        // Now in S_DONE; ready_i is still high with the stale column.
        checks++;
        if (done_o !== 1'b1 || idle_o !== 1'b1 || pix_valid_o !== 1'b1 || pix_x_o !== 8'd2) begin
            errors++;
            $display("FAIL done_cycle: got done=%0b idle=%0b valid=%0b x=%0d, required 1 1 1 2", done_o, idle_o, pix_valid_o, pix_x_o);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b0 || idle_o !== 1'b1 || pix_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got done=%0b idle=%0b valid=%0b, required 0 1 0", done_o, idle_o, pix_valid_o);
        end
        q_pix.delete();
        q_x.delete();
        send_row_ramp();
        checks++;
        if (q_pix.size() !== 3 || done_cnt !== 2) begin
            errors++;
            $display("FAIL done_next_row: got pixels=%0d done_cnt=%0d, required 3 2", q_pix.size(), done_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pix[i] !== exp_pix[i] || q_x[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL done_next_pix %0d: got pix=%0d x=%0d, required pix=%0d x=%0d", i, q_pix[i], q_x[i], exp_pix[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_midrow();
        do_reset();
        send_row_const(8'd10);
        send_col(8'd20, 8'd20, 8'd20);
        send_col(8'd20, 8'd20, 8'd20);
        send_col(8'd20, 8'd20, 8'd20);
        // Pixel of the third capture is on the outputs right now.
        ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({idle_o, done_o, pix_o, pix_valid_o, pix_x_o, frame_done_o} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: idle=%0b done=%0b pix=%0d valid=%0b x=%0d fd=%0b, required 1 0 0 0 0 0",
                     idle_o, done_o, pix_o, pix_valid_o, pix_x_o, frame_done_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_pix.delete();
        q_x.delete();
        done_cnt = 0;
        send_row_const(8'd40);
        send_row_const(8'd40);
        checks++;
        if (frame_done_o !== 1'b0 || q_pix.size() !== 6) begin
            errors++;
            $display("FAIL reset_row_restart: got fd=%0b pixels=%0d after 2 rows, required 0 6", frame_done_o, q_pix.size());
        end
        send_row_const(8'd40);
        checks++;
        if (frame_done_o !== 1'b1 || q_pix.size() !== 9 || done_cnt !== 3) begin
            errors++;
            $display("FAIL reset_frame: got fd=%0b pixels=%0d done=%0d, required 1 9 3", frame_done_o, q_pix.size(), done_cnt);
        end
        for (int i = 0; i < q_pix.size(); i++) begin
            checks++;
            if (q_pix[i] !== 8'd40 || q_x[i] !== 8'(i % 3)) begin
                errors++;
                $display("FAIL reset_pix %0d: got pix=%0d x=%0d, required pix=40 x=%0d", i, q_pix[i], q_x[i], i % 3);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ready_i      = 1'b0;
        fifo1_data_i = 8'd0;
        fifo2_data_i = 8'd0;
        fifo3_data_i = 8'd0;
        test_reset();
        test_uniform();
        test_impulse();
        test_saturate();
        test_stall();
        test_done_ready_held();
        test_reset_midrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
